// File: rtl/jk_ff_monitor.sv
// ---------------------------------------------------------------------------
// jk_ff_monitor
//
// Purpose:
//   Self-checking response monitor for a single JK flip-flop. It taps the
//   J/K values driven to the flop, observes Q/nQ, and runs its own JK model.
//   The model is seeded once from the observed Q and then runs free. Every
//   checked edge compares the model against Q and checks that nQ is the
//   complement of Q. Mismatches are pulsed, counted and latched.
//
// Parameters:
//   LATENCY      clock edges between a J/K sample and the Q edge reflecting it (1..4)
//   CNT_W        width of every counter; counters saturate at all-ones
//   STOP_ON_ERR  1: freeze in HALT on the first error until clr or reset
//
// Optional feature:
//   JK_FF_MONITOR_COVER_EN  when defined, builds per-JK-code coverage counters.
//   When undefined, the cov_* ports stay and are tied to 0.
//
// Ports:
//   clk          rising-edge clock shared with the observed flop
//   rst_n        asynchronous active-low reset
//   en           checking enable; 0 returns the monitor to IDLE (except from HALT)
//   clr          synchronous clear of counters and sticky flag; forces IDLE
//   j, k         J/K as driven to the observed flop
//   q, nq        observed Q and nQ
//   exp_q        model-predicted Q
//   err_pulse    registered one-cycle mismatch indication
//   err_sticky   latched error flag
//   err_count    number of erroring checked edges
//   check_count  number of checked edges
//   state        00 IDLE, 01 SYNC, 10 CHECK, 11 HALT
//   cov_hold/cov_rst/cov_set/cov_tgl  checked edges per JK code 00/01/10/11
//   cov_done     all four coverage counters non-zero
// ---------------------------------------------------------------------------
module jk_ff_monitor #(
    parameter int LATENCY     = 1,
    parameter int CNT_W       = 16,
    parameter int STOP_ON_ERR = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             j,
    input  logic             k,
    input  logic             q,
    input  logic             nq,
    output logic             exp_q,
    output logic             err_pulse,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] check_count,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] cov_hold,
    output logic [CNT_W-1:0] cov_rst,
    output logic [CNT_W-1:0] cov_set,
    output logic [CNT_W-1:0] cov_tgl,
    output logic             cov_done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SYNC  = 2'b01,
        ST_CHECK = 2'b10,
        ST_HALT  = 2'b11
    } state_t;

    // Saturating increment: counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (&v) begin
            r = v;
        end else begin
            r = v + CNT_W'(1);
        end
        return r;
    endfunction

    // JK next-state rule: 00 hold, 01 reset, 10 set, 11 toggle.
    function automatic logic jk_next(input logic [1:0] jk, input logic x);
        logic r;
        case (jk)
            2'b00:   r = x;
            2'b01:   r = 1'b0;
            2'b10:   r = 1'b1;
            default: r = ~x;
        endcase
        return r;
    endfunction

    logic [1:0] jk_now;
    logic [1:0] jk_sel;

    assign jk_now = {j, k};

    // J/K alignment: the model must use the J/K value that the observed Q
    // edge actually reflects, i.e. the one sampled LATENCY-1 edges ago.
    generate
        if (LATENCY <= 1) begin : g_no_pipe
            assign jk_sel = jk_now;
        end else begin : g_pipe
            logic [1:0] jk_pipe_q [LATENCY-1];
            logic [1:0] jk_pipe_d [LATENCY-1];

            always_comb begin
                jk_pipe_d[0] = jk_now;
                for (int i = 1; i < LATENCY - 1; i++) begin
                    jk_pipe_d[i] = jk_pipe_q[i-1];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < LATENCY - 1; i++) begin
                        jk_pipe_q[i] <= 2'b00;
                    end
                end else begin
                    jk_pipe_q <= jk_pipe_d;
                end
            end

            assign jk_sel = jk_pipe_q[LATENCY-2];
        end
    endgenerate

    state_t           state_q,       state_d;
    logic             model_q,       model_d;
    logic             err_pulse_q,   err_pulse_d;
    logic             err_sticky_q,  err_sticky_d;
    logic [CNT_W-1:0] err_count_q,   err_count_d;
    logic [CNT_W-1:0] check_count_q, check_count_d;
    logic             mismatch;

    // Wrong Q against the model, or nQ not the complement of Q.
    assign mismatch = (q != model_q) || (nq == q);

    always_comb begin
        state_d       = state_q;
        model_d       = model_q;
        err_pulse_d   = 1'b0;
        err_sticky_d  = err_sticky_q;
        err_count_d   = err_count_q;
        check_count_d = check_count_q;

        if (clr) begin
            // Clear beats everything, including a mismatch on the same edge.
            state_d       = ST_IDLE;
            err_sticky_d  = 1'b0;
            err_count_d   = '0;
            check_count_d = '0;
        end else if (!en && (state_q != ST_HALT)) begin
            // The in-flight edge is dropped unchecked.
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_SYNC;
                end
                ST_SYNC: begin
                    // Seed the model from the observed Q; no check this edge.
                    model_d = jk_next(jk_sel, q);
                    state_d = ST_CHECK;
                end
                ST_CHECK: begin
                    check_count_d = sat_inc(check_count_q);
                    if (mismatch) begin
                        err_count_d  = sat_inc(err_count_q);
                        err_pulse_d  = 1'b1;
                        err_sticky_d = 1'b1;
                        if (STOP_ON_ERR != 0) begin
                            state_d = ST_HALT;
                        end
                    end
                    // Free-running: never resync to q, so a stuck flop keeps erroring.
                    model_d = jk_next(jk_sel, model_q);
                end
                default: begin
                    // HALT holds everything until clr or reset.
                    state_d = ST_HALT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            model_q       <= 1'b0;
            err_pulse_q   <= 1'b0;
            err_sticky_q  <= 1'b0;
            err_count_q   <= '0;
            check_count_q <= '0;
        end else begin
            state_q       <= state_d;
            model_q       <= model_d;
            err_pulse_q   <= err_pulse_d;
            err_sticky_q  <= err_sticky_d;
            err_count_q   <= err_count_d;
            check_count_q <= check_count_d;
        end
    end

    assign state       = state_q;
    assign exp_q       = model_q;
    assign err_pulse   = err_pulse_q;
    assign err_sticky  = err_sticky_q;
    assign err_count   = err_count_q;
    assign check_count = check_count_q;

`ifdef JK_FF_MONITOR_COVER_EN
    logic [CNT_W-1:0] cov_q [4];
    logic [CNT_W-1:0] cov_d [4];
    logic             cov_edge;

    // Same qualification as a counted check: CHECK state, enabled, not cleared.
    assign cov_edge = (state_q == ST_CHECK) && en && !clr;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            cov_d[i] = cov_q[i];
        end
        if (clr) begin
            for (int i = 0; i < 4; i++) begin
                cov_d[i] = '0;
            end
        end else if (cov_edge) begin
            cov_d[jk_sel] = sat_inc(cov_q[jk_sel]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                cov_q[i] <= '0;
            end
        end else begin
            cov_q <= cov_d;
        end
    end

    assign cov_hold = cov_q[0];
    assign cov_rst  = cov_q[1];
    assign cov_set  = cov_q[2];
    assign cov_tgl  = cov_q[3];
    assign cov_done = (|cov_q[0]) && (|cov_q[1]) && (|cov_q[2]) && (|cov_q[3]);
`else
    assign cov_hold = '0;
    assign cov_rst  = '0;
    assign cov_set  = '0;
    assign cov_tgl  = '0;
    assign cov_done = 1'b0;
`endif

endmodule
